// File: rtl/hex_share_arbiter.sv
// hex_share_arbiter
// Time-shares the six-digit HEX display between three sources (idle blinker,
// running ms counter, result hold). One source is granted at a time and is
// kept on screen for at least MIN_HOLD ms_clk cycles before re-arbitration.
// Registered digit codes feed the existing per-digit seven-segment decoders.
//
// Build option: define HEX_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// leave it undefined for fixed priority (lowest index wins).
module hex_share_arbiter #(
    parameter int unsigned MIN_HOLD = 200,
    parameter logic [3:0]  BLANK    = 4'b1111
) (
    input  logic        ms_clk,
    input  logic        Reset_n,
    input  logic [2:0]  req,
    input  logic [23:0] src0_digits,
    input  logic [23:0] src1_digits,
    input  logic [23:0] src2_digits,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [3:0]  d4,
    output logic [3:0]  d5
);

    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  HOLD     = 1'b1;
    localparam logic [11:0] HOLD_MAX = 12'(MIN_HOLD);

    logic [0:0]  state_reg, state_next;
    logic [11:0] hold_cnt_reg, hold_cnt_next;
    logic [2:0]  grant_reg, grant_next;
    logic        busy_reg;
    logic [23:0] digits_reg, digits_next;
    logic [2:0]  winner;

`ifdef HEX_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_reg, rr_ptr_next;
    logic [1:0] rr_start;
    logic [1:0] rr_cand [3];

    function automatic logic [1:0] next3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin winner. While holding, the search starts after the current
    // holder so it is considered last; from IDLE there is no holder to yield,
    // so the search starts at the pointer itself (source 0 after reset).
    always_comb begin
        rr_start   = (state_reg == HOLD) ? next3(rr_ptr_reg) : rr_ptr_reg;
        rr_cand[0] = rr_start;
        rr_cand[1] = next3(rr_start);
        rr_cand[2] = next3(rr_cand[1]);
        winner     = 3'b000;
        if (req[rr_cand[2]]) winner = 3'b001 << rr_cand[2];
        if (req[rr_cand[1]]) winner = 3'b001 << rr_cand[1];
        if (req[rr_cand[0]]) winner = 3'b001 << rr_cand[0];
    end

    // Pointer follows the index of every newly granted source.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_next != 3'b000 && grant_next != grant_reg) begin
            rr_ptr_next = grant_next[2] ? 2'd2 : (grant_next[1] ? 2'd1 : 2'd0);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge ms_clk or negedge Reset_n) begin
        if (!Reset_n) rr_ptr_reg <= 2'd0;
        else          rr_ptr_reg <= rr_ptr_next;
    end
`else
    // Fixed priority winner: lowest requesting index.
    always_comb begin
        winner = 3'b000;
        if      (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
    end
`endif

    // Grant state machine: freeze during the minimum hold, then re-arbitrate
    // every edge until nothing requests.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req != 3'b000) begin
                    state_next    = HOLD;
                    grant_next    = winner;
                    hold_cnt_next = 12'd1;
                end
            end
            default: begin
                if (hold_cnt_reg < HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + 12'd1;
                end else if (req == 3'b000) begin
                    state_next    = IDLE;
                    grant_next    = 3'b000;
                    hold_cnt_next = 12'd0;
                end else if (winner != grant_reg) begin
                    grant_next    = winner;
                    hold_cnt_next = 12'd1;
                end
            end
        endcase
    end

    // Per-digit mux from the source that will be granted after this edge, so
    // a switch shows the new digits on the same edge as the new grant.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit_mux
            assign digits_next[gi*4 +: 4] =
                grant_next[0] ? src0_digits[gi*4 +: 4] :
                grant_next[1] ? src1_digits[gi*4 +: 4] :
                grant_next[2] ? src2_digits[gi*4 +: 4] : BLANK;
        end
    endgenerate

    // State, counter and output registers.
    always_ff @(posedge ms_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= 12'd0;
            grant_reg    <= 3'b000;
            busy_reg     <= 1'b0;
            digits_reg   <= {6{BLANK}};
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            grant_reg    <= grant_next;
            busy_reg     <= |grant_next;
            digits_reg   <= digits_next;
        end
    end

    assign grant = grant_reg;
    assign busy  = busy_reg;
    assign d0    = digits_reg[3:0];
    assign d1    = digits_reg[7:4];
    assign d2    = digits_reg[11:8];
    assign d3    = digits_reg[15:12];
    assign d4    = digits_reg[19:16];
    assign d5    = digits_reg[23:20];

endmodule

// File: tb/tb_hex_share_arbiter.sv
// Testbench for hex_share_arbiter (MIN_HOLD=4). Works with or without
// HEX_ARB_ROUND_ROBIN_EN defined; the reference model follows the same macro.
module tb_hex_share_arbiter;

    localparam int MH = 4;

    logic        ms_clk = 1'b0;
    logic        Reset_n;
    logic [2:0]  req;
    logic [23:0] src0_digits, src1_digits, src2_digits;
    logic [2:0]  grant;
    logic        busy;
    logic [3:0]  d0, d1, d2, d3, d4, d5;

    int checks = 0;
    int errors = 0;

    // Reference model: who is on screen, for how many cycles, who went last.
    int          m_holder;
    int          m_held;
    int          m_last;
    logic [23:0] m_digits;

    hex_share_arbiter #(.MIN_HOLD(MH), .BLANK(4'b1111)) dut (
        .ms_clk(ms_clk), .Reset_n(Reset_n), .req(req),
        .src0_digits(src0_digits), .src1_digits(src1_digits), .src2_digits(src2_digits),
        .grant(grant), .busy(busy),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5)
    );

    always #5 ms_clk = ~ms_clk;

    function automatic logic [30:0] observed();
        return {grant, busy, d5, d4, d3, d2, d1, d0};
    endfunction

    function automatic logic [30:0] expected();
        if (m_holder < 0) return {3'b000, 1'b0, 24'hFFFFFF};
        return {3'(1 << m_holder), 1'b1, m_digits};
    endfunction

    function automatic logic [23:0] src_of(int k);
        return (k == 0) ? src0_digits : (k == 1) ? src1_digits : src2_digits;
    endfunction

    // First requesting source scanning from 'start' with wrap-around.
    function automatic int pick(logic [2:0] r, int start);
        for (int off = 0; off < 3; off++) begin
            int idx;
            idx = (start + off) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_held   = 0;
        m_last   = 0;
        m_digits = 24'hFFFFFF;
    endtask

    function automatic int choose(logic [2:0] r, bit holding);
`ifdef HEX_ARB_ROUND_ROBIN_EN
        return pick(r, holding ? (m_last + 1) % 3 : m_last);
`else
        return pick(r, 0);
`endif
    endfunction

    // One clock edge: advance the model with the inputs sampled at the edge.
    task automatic tick();
        int w;
        @(posedge ms_clk);
        if (!Reset_n) begin
            model_reset();
        end else if (m_holder < 0) begin
            if (req != 3'b000) begin
                m_holder = choose(req, 1'b0);
                m_held   = 1;
                m_last   = m_holder;
            end
        end else if (m_held < MH) begin
            m_held++;
        end else if (req == 3'b000) begin
            m_holder = -1;
        end else begin
            w = choose(req, 1'b1);
            if (w != m_holder) begin
                m_holder = w;
                m_held   = 1;
                m_last   = w;
            end
        end
        m_digits = (m_holder < 0) ? 24'hFFFFFF : src_of(m_holder);
        #1;
        $display("t=%0t req=%b grant=%b busy=%b digits=%h", $time, req, grant, busy,
                 {d5, d4, d3, d2, d1, d0});
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        req     = 3'b000;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        req     = 3'b111;
        src0_digits = 24'hABCDEF; src1_digits = 24'h123456; src2_digits = 24'h777777;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({grant, busy, d5, d4, d3, d2, d1, d0} !== {3'b000, 1'b0, 24'hFFFFFF}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", observed(), {3'b000, 1'b0, 24'hFFFFFF});
        end
        Reset_n = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 001", grant);
        end
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_single_source();
        do_reset();
        src1_digits = 24'h123456;
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010 || d0 !== 4'h6 || d5 !== 4'h1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b d0=%h d5=%h want 010 6 1", grant, d0, d5);
        end
        src1_digits = 24'h000009;
        tick();
        checks++;
        if (d0 !== 4'h9 || d5 !== 4'h0) begin
            errors++;
            $display("FAIL single_live_update: got d0=%h d5=%h want 9 0", d0, d5);
        end
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL single_model: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 3'b100;
        tick();
        req = 3'b000;
        for (int e = 1; e <= MH - 1; e++) begin
            tick();
            checks++;
            if (grant !== 3'b100 || busy !== 1'b1) begin
                errors++;
                $display("FAIL early_drop_hold edge%0d: got grant=%b busy=%b want 100 1", e, grant, busy);
            end
        end
        tick();
        checks++;
        if ({grant, busy, d5, d4, d3, d2, d1, d0} !== {3'b000, 1'b0, 24'hFFFFFF}) begin
            errors++;
            $display("FAIL early_drop_release: got %h want %h", observed(), {3'b000, 1'b0, 24'hFFFFFF});
        end
    endtask

    task automatic test_priority_switch();
        do_reset();
        req = 3'b100;
        tick();
        req = 3'b101;
        for (int e = 1; e <= MH - 1; e++) begin
            tick();
            checks++;
            if (grant !== 3'b100) begin
                errors++;
                $display("FAIL prio_frozen edge%0d: got %b want 100", e, grant);
            end
        end
        tick();
        checks++;
        if (grant !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_switch: got grant=%b busy=%b want 001 1", grant, busy);
        end
        req = 3'b111;
        for (int e = 0; e < 3 * MH; e++) begin
            tick();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL prio_all_model edge%0d: got %h want %h", e, observed(), expected());
            end
`ifndef HEX_ARB_ROUND_ROBIN_EN
            checks++;
            if (grant !== 3'b001) begin
                errors++;
                $display("FAIL prio_sticky edge%0d: got %b want 001", e, grant);
            end
`endif
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [4];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
        do_reset();
        req = 3'b111;
        for (int e = 0; e < 4 * MH; e++) begin
            tick();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL rr_model edge%0d: got %h want %h", e, observed(), expected());
            end
`ifdef HEX_ARB_ROUND_ROBIN_EN
            checks++;
            if (grant !== seq[e / MH] || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_sequence edge%0d: got grant=%b busy=%b want %b 1", e, grant, busy, seq[e / MH]);
            end
`else
            checks++;
            if (grant !== seq[0]) begin
                errors++;
                $display("FAIL rr_fixed edge%0d: got %b want 001", e, grant);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 3'b010;
        tick();
        tick();
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({grant, busy, d5, d4, d3, d2, d1, d0} !== {3'b000, 1'b0, 24'hFFFFFF}) begin
            errors++;
            $display("FAIL reset_mid_hold: got %h want %h", observed(), {3'b000, 1'b0, 24'hFFFFFF});
        end
        tick();
        Reset_n = 1'b1;
        req = 3'b111;
        tick();
        checks++;
        if (grant !== 3'b001 || observed() !== expected()) begin
            errors++;
            $display("FAIL reset_mid_hold_regrant: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            src0_digits = 24'($urandom);
            src1_digits = 24'($urandom);
            src2_digits = 24'($urandom);
            tick();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random_model step%0d: got %h want %h", n, observed(), expected());
            end
            checks++;
            if (busy !== (|grant) || (grant & (grant - 3'd1)) !== 3'b000) begin
                errors++;
                $display("FAIL random_onehot step%0d: got grant=%b busy=%b want onehot/zero and busy=|grant", n, grant, busy);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        req = 3'b000;
        src0_digits = 24'h0; src1_digits = 24'h0; src2_digits = 24'h0;
        model_reset();
        test_reset();
        test_single_source();
        test_early_drop();
        test_priority_switch();
        test_round_robin();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
